// File: rtl/peak_k_shell_pkg.sv
// peak_k_shell_pkg -- shared constants and types for the peak_k_shell slice.
//
// Holds the project-wide default constants (VALUE_WIDTH, INDEX_WIDTH,
// PEAK_HOLDOFF, NUM_BINS, NUM_PEAKS). Each one can be overridden with a
// command-line define. Also holds the FSM state type and a ring-distance
// helper for bin indices.
// Optional feature macro used by this slice: PEAK_SIDE_EN (adds side_o).
`ifndef VALUE_WIDTH
`define VALUE_WIDTH 8
`endif
`ifndef INDEX_WIDTH
`define INDEX_WIDTH 8
`endif
`ifndef PEAK_HOLDOFF
`define PEAK_HOLDOFF 3
`endif
`ifndef NUM_BINS
`define NUM_BINS 256
`endif
`ifndef NUM_PEAKS
`define NUM_PEAKS 4
`endif

package peak_k_shell_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // Shortest distance between two bin indices on a ring of 2^width bins.
  function automatic int unsigned ring_dist(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned width);
    int unsigned mask;
    int unsigned d1;
    int unsigned d2;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    d1 = (a - b) & mask;
    d2 = (b - a) & mask;
    return (d1 < d2) ? d1 : d2;
  endfunction

endpackage

// File: rtl/peak_topk_list.sv
// peak_topk_list -- sorted top-K peak list with holdoff replacement.
//
// Ports:
//   clk, aresetn          clock, async active-low reset
//   cand_en               candidate present this cycle
//   cand_val / cand_idx   candidate value and bin index
//   clear                 empty the list at this edge (end of frame)
//   nxt_val / nxt_idx     post-update list, slot 0 largest, unused slots 0
//   nxt_cnt               post-update number of valid slots
//   cand_side / nxt_side  (PEAK_SIDE_EN only) side flag carried with entries
// The nxt_* outputs are combinational, so the caller can publish the list
// including the candidate of the same beat.
module peak_topk_list
  import peak_k_shell_pkg::*;
#(
  parameter int NUM_PEAKS   = `NUM_PEAKS,
  parameter int VALUE_WIDTH = `VALUE_WIDTH,
  parameter int INDEX_WIDTH = `INDEX_WIDTH,
  parameter int HOLDOFF     = `PEAK_HOLDOFF
) (
  input  logic                               clk,
  input  logic                               aresetn,
  input  logic                               cand_en,
  input  logic [VALUE_WIDTH-1:0]             cand_val,
  input  logic [INDEX_WIDTH-1:0]             cand_idx,
  input  logic                               clear,
  output logic [NUM_PEAKS*VALUE_WIDTH-1:0]   nxt_val,
  output logic [NUM_PEAKS*INDEX_WIDTH-1:0]   nxt_idx,
  output logic [$clog2(NUM_PEAKS+1)-1:0]     nxt_cnt
`ifdef PEAK_SIDE_EN
  ,
  input  logic                               cand_side,
  output logic [NUM_PEAKS-1:0]               nxt_side
`endif
);

  localparam int CW = $clog2(NUM_PEAKS + 1);
  localparam int PW = (NUM_PEAKS > 1) ? $clog2(NUM_PEAKS) : 1;

  logic [VALUE_WIDTH-1:0] val_q [NUM_PEAKS];
  logic [INDEX_WIDTH-1:0] idx_q [NUM_PEAKS];
  logic [VALUE_WIDTH-1:0] r_val [NUM_PEAKS];
  logic [INDEX_WIDTH-1:0] r_idx [NUM_PEAKS];
  logic [VALUE_WIDTH-1:0] n_val [NUM_PEAKS];
  logic [INDEX_WIDTH-1:0] n_idx [NUM_PEAKS];
  logic [CW-1:0]          cnt_q, r_cnt, n_cnt, pos;
  logic [PW-1:0]          hit_pos;
  logic                   hit, drop, do_ins;
`ifdef PEAK_SIDE_EN
  logic [NUM_PEAKS-1:0]   side_q, r_side, n_side;
`endif

  always_comb begin
    hit     = 1'b0;
    hit_pos = '0;
    // First (largest) stored entry inside the holdoff zone owns the candidate.
    for (int i = 0; i < NUM_PEAKS; i++) begin
      if (!hit && (CW'(i) < cnt_q) &&
          (ring_dist(32'(cand_idx), 32'(idx_q[i]), INDEX_WIDTH) <= 32'(HOLDOFF))) begin
        hit     = 1'b1;
        hit_pos = PW'(i);
      end
    end
    drop   = cand_en && hit && (cand_val > val_q[hit_pos]);
    do_ins = cand_en && (!hit || drop);

    // A replaced entry is removed first, then the candidate is inserted
    // like a fresh one; this keeps the list sorted in all cases.
    r_val = val_q;
    r_idx = idx_q;
    r_cnt = cnt_q;
`ifdef PEAK_SIDE_EN
    r_side = side_q;
`endif
    if (drop) begin
      for (int i = 0; i < NUM_PEAKS - 1; i++) begin
        if (PW'(i) >= hit_pos) begin
          r_val[i] = val_q[i+1];
          r_idx[i] = idx_q[i+1];
`ifdef PEAK_SIDE_EN
          r_side[i] = side_q[i+1];
`endif
        end
      end
      r_val[NUM_PEAKS-1] = '0;
      r_idx[NUM_PEAKS-1] = '0;
`ifdef PEAK_SIDE_EN
      r_side[NUM_PEAKS-1] = 1'b0;
`endif
      r_cnt = cnt_q - 1'b1;
    end

    // Entries >= candidate stay ahead of it, so ties keep the older entry.
    pos = '0;
    for (int i = 0; i < NUM_PEAKS; i++) begin
      if ((CW'(i) < r_cnt) && (r_val[i] >= cand_val)) pos = pos + 1'b1;
    end

    n_val = r_val;
    n_idx = r_idx;
    n_cnt = r_cnt;
`ifdef PEAK_SIDE_EN
    n_side = r_side;
`endif
    if (do_ins && (pos < CW'(NUM_PEAKS))) begin
      for (int i = 1; i < NUM_PEAKS; i++) begin
        if (CW'(i) > pos) begin
          n_val[i] = r_val[i-1];
          n_idx[i] = r_idx[i-1];
`ifdef PEAK_SIDE_EN
          n_side[i] = r_side[i-1];
`endif
        end
      end
      n_val[pos[PW-1:0]] = cand_val;
      n_idx[pos[PW-1:0]] = cand_idx;
`ifdef PEAK_SIDE_EN
      n_side[pos[PW-1:0]] = cand_side;
`endif
      if (r_cnt < CW'(NUM_PEAKS)) n_cnt = r_cnt + 1'b1;
    end

    nxt_val = '0;
    nxt_idx = '0;
    for (int i = 0; i < NUM_PEAKS; i++) begin
      nxt_val[i*VALUE_WIDTH +: VALUE_WIDTH] = n_val[i];
      nxt_idx[i*INDEX_WIDTH +: INDEX_WIDTH] = n_idx[i];
    end
    nxt_cnt = n_cnt;
`ifdef PEAK_SIDE_EN
    nxt_side = n_side;
`endif
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q <= '0;
      for (int i = 0; i < NUM_PEAKS; i++) begin
        val_q[i] <= '0;
        idx_q[i] <= '0;
      end
`ifdef PEAK_SIDE_EN
      side_q <= '0;
`endif
    end else if (clear) begin
      cnt_q <= '0;
      for (int i = 0; i < NUM_PEAKS; i++) begin
        val_q[i] <= '0;
        idx_q[i] <= '0;
      end
`ifdef PEAK_SIDE_EN
      side_q <= '0;
`endif
    end else begin
      cnt_q <= n_cnt;
      for (int i = 0; i < NUM_PEAKS; i++) begin
        val_q[i] <= n_val[i];
        idx_q[i] <= n_idx[i];
      end
`ifdef PEAK_SIDE_EN
      side_q <= n_side;
`endif
    end
  end

endmodule

// File: rtl/peak_k_shell.sv
// peak_k_shell -- per-frame top-K local-maximum detector.
//
// Ports:
//   clk, aresetn          clock, async active-low reset
//   valid, last           beat qualifier, final beat of frame
//   input_i, index_i      sample and its bin index
//   threshold_i           a peak must exceed this value
//   peak_o, index_o       published peaks (slot 0 largest), unused slots 0
//   count_o               number of valid published slots
//   out_valid, last_out   one-cycle publish pulse (identical)
//   side_o                (PEAK_SIDE_EN only) per peak: newest tap >= oldest tap
//
// state    | meaning
// ---------+---------------------------------------------------
// ST_IDLE  | after reset, no beat seen yet
// ST_FILL  | window not yet filled with beats of current frame
// ST_RUN   | window full, local-max detection active
module peak_k_shell
  import peak_k_shell_pkg::*;
#(
  parameter int NUM_PEAKS   = `NUM_PEAKS,
  parameter int VALUE_WIDTH = `VALUE_WIDTH,
  parameter int INDEX_WIDTH = `INDEX_WIDTH,
  parameter int HALF_WIN    = 2,
  parameter int HOLDOFF     = `PEAK_HOLDOFF
) (
  input  logic                               clk,
  input  logic                               aresetn,
  input  logic                               valid,
  input  logic                               last,
  input  logic [VALUE_WIDTH-1:0]             input_i,
  input  logic [INDEX_WIDTH-1:0]             index_i,
  input  logic [VALUE_WIDTH-1:0]             threshold_i,
  output logic [NUM_PEAKS*VALUE_WIDTH-1:0]   peak_o,
  output logic [NUM_PEAKS*INDEX_WIDTH-1:0]   index_o,
  output logic [$clog2(NUM_PEAKS+1)-1:0]     count_o,
  output logic                               out_valid,
  output logic                               last_out
`ifdef PEAK_SIDE_EN
  ,
  output logic [NUM_PEAKS-1:0]               side_o
`endif
);

  localparam int TAPS = 2 * HALF_WIN + 1;
  localparam int FCW  = $clog2(TAPS + 1);

  state_t                            state;
  logic [FCW-1:0]                    fill_cnt;
  // hist[0] is the oldest stored sample; the live input completes the window.
  logic [VALUE_WIDTH-1:0]            hist [TAPS-1];
  logic [VALUE_WIDTH-1:0]            tap  [TAPS];
  logic                              win_full, is_peak, cand_en, frame_end;
  logic [INDEX_WIDTH-1:0]            cand_idx;
  logic [NUM_PEAKS*VALUE_WIDTH-1:0]  nxt_val;
  logic [NUM_PEAKS*INDEX_WIDTH-1:0]  nxt_idx;
  logic [$clog2(NUM_PEAKS+1)-1:0]    nxt_cnt;
`ifdef PEAK_SIDE_EN
  logic [NUM_PEAKS-1:0]              nxt_side;
  logic                              cand_side;
`endif

  // The beat that completes the window is evaluated in the same cycle it
  // arrives, so the FILL->RUN beat already counts as a full window.
  assign win_full  = (state == ST_RUN) || (fill_cnt == FCW'(TAPS - 1));
  assign frame_end = valid && last;
  assign cand_idx  = index_i - INDEX_WIDTH'(HALF_WIN);
  assign last_out  = out_valid;

  always_comb begin
    for (int i = 0; i < TAPS - 1; i++) tap[i] = hist[i];
    tap[TAPS-1] = input_i;
    // Strict against older taps, non-strict against newer ones: a plateau
    // reports its first sample only.
    is_peak = 1'b1;
    for (int i = 0; i < HALF_WIN; i++)
      if (!(tap[HALF_WIN] > tap[i])) is_peak = 1'b0;
    for (int i = HALF_WIN + 1; i < TAPS; i++)
      if (!(tap[HALF_WIN] >= tap[i])) is_peak = 1'b0;
    cand_en = valid && win_full && is_peak && (tap[HALF_WIN] > threshold_i);
  end

`ifdef PEAK_SIDE_EN
  assign cand_side = (tap[TAPS-1] >= tap[0]);
`endif

  peak_topk_list #(
    .NUM_PEAKS   (NUM_PEAKS),
    .VALUE_WIDTH (VALUE_WIDTH),
    .INDEX_WIDTH (INDEX_WIDTH),
    .HOLDOFF     (HOLDOFF)
  ) u_list (
    .clk       (clk),
    .aresetn   (aresetn),
    .cand_en   (cand_en),
    .cand_val  (tap[HALF_WIN]),
    .cand_idx  (cand_idx),
    .clear     (frame_end),
    .nxt_val   (nxt_val),
    .nxt_idx   (nxt_idx),
    .nxt_cnt   (nxt_cnt)
`ifdef PEAK_SIDE_EN
    ,
    .cand_side (cand_side),
    .nxt_side  (nxt_side)
`endif
  );

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= ST_IDLE;
      fill_cnt  <= '0;
      for (int i = 0; i < TAPS - 1; i++) hist[i] <= '0;
      peak_o    <= '0;
      index_o   <= '0;
      count_o   <= '0;
      out_valid <= 1'b0;
`ifdef PEAK_SIDE_EN
      side_o    <= '0;
`endif
    end else begin
      out_valid <= frame_end;
      if (valid) begin
        for (int i = 0; i < TAPS - 2; i++) hist[i] <= hist[i+1];
        hist[TAPS-2] <= input_i;
        if (last) begin
          state    <= ST_FILL;
          fill_cnt <= '0;
          peak_o   <= nxt_val;
          index_o  <= nxt_idx;
          count_o  <= nxt_cnt;
`ifdef PEAK_SIDE_EN
          side_o   <= nxt_side;
`endif
        end else if (state != ST_RUN) begin
          fill_cnt <= fill_cnt + 1'b1;
          state    <= (fill_cnt == FCW'(TAPS - 1)) ? ST_RUN : ST_FILL;
        end
      end
    end
  end

endmodule

// File: tb/tb_peak_k_shell.sv
// tb_peak_k_shell -- directed, table-driven bench for peak_k_shell
// (K=4, W=2, HOLDOFF=3, threshold 10). Define PEAK_SIDE_EN to also check side_o.
module tb_peak_k_shell;
  localparam int K  = 4;
  localparam int VW = 8;
  localparam int IW = 8;
  localparam int CW = $clog2(K + 1);
  localparam int NF = 15;

  logic            clk = 1'b0;
  logic            aresetn = 1'b1;
  logic            valid = 1'b0;
  logic            last = 1'b0;
  logic [VW-1:0]   input_i = '0;
  logic [IW-1:0]   index_i = '0;
  logic [VW-1:0]   threshold_i = 8'd10;
  logic [K*VW-1:0] peak_o;
  logic [K*IW-1:0] index_o;
  logic [CW-1:0]   count_o;
  logic            out_valid;
  logic            last_out;
`ifdef PEAK_SIDE_EN
  logic [K-1:0]    side_o;
`endif

  peak_k_shell #(
    .NUM_PEAKS(K), .VALUE_WIDTH(VW), .INDEX_WIDTH(IW), .HALF_WIN(2), .HOLDOFF(3)
  ) dut (
    .clk(clk), .aresetn(aresetn), .valid(valid), .last(last),
    .input_i(input_i), .index_i(index_i), .threshold_i(threshold_i),
    .peak_o(peak_o), .index_o(index_o), .count_o(count_o),
    .out_valid(out_valid), .last_out(last_out)
`ifdef PEAK_SIDE_EN
    , .side_o(side_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]       len;
    logic [7:0]       base;
    logic [31:0][7:0] samp;
    logic [3:0][7:0]  ep;
    logic [3:0][7:0]  ei;
    logic [2:0]       ec;
    logic [3:0]       es;
  } frame_t;

  frame_t frames [NF];
  int     n_checks = 0;
  int     n_pass = 0;
  logic   pend = 1'b0;
  int     pend_f = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Sample at the falling edge; a pending publish is checked one cycle after its last beat.
  task automatic tick();
    @(negedge clk);
    chk("out_valid", 64'(out_valid), 64'(pend));
    chk("last_out", 64'(last_out), 64'(pend));
    if (pend) begin
      chk($sformatf("peak_o f%0d", pend_f), 64'(peak_o), 64'(frames[pend_f].ep));
      chk($sformatf("index_o f%0d", pend_f), 64'(index_o), 64'(frames[pend_f].ei));
      chk($sformatf("count_o f%0d", pend_f), 64'(count_o), 64'(frames[pend_f].ec));
`ifdef PEAK_SIDE_EN
      chk($sformatf("side_o f%0d", pend_f), 64'(side_o), 64'(frames[pend_f].es));
`endif
      pend = 1'b0;
    end
  endtask

  task automatic run_frame(input int f, input bit gaps);
    int len;
    len = int'(frames[f].len);
    for (int b = 0; b < len; b++) begin
      tick();
      valid   = 1'b1;
      last    = (b == len - 1);
      input_i = frames[f].samp[b];
      index_i = frames[f].base + 8'(b);
      if (b == len - 1) begin
        pend   = 1'b1;
        pend_f = f;
      end else if (gaps) begin
        tick();
        valid   = 1'b0;
        last    = 1'b1;
        input_i = 8'hFF;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      valid = 1'b0;
      last  = 1'b0;
    end
  endtask

  initial begin
    for (int f = 0; f < NF; f++) frames[f] = '0;
    // 0: basic three peaks
    frames[0].len = 13; frames[0].samp[2] = 50; frames[0].samp[6] = 80; frames[0].samp[10] = 30;
    frames[0].ep = {8'd0, 8'd30, 8'd50, 8'd80}; frames[0].ei = {8'd0, 8'd10, 8'd2, 8'd6};
    frames[0].ec = 3; frames[0].es = 4'b0111;
    // 1: same, indices wrap through 255 -> 0
    frames[1] = frames[0]; frames[1].base = 252;
    frames[1].ei = {8'd0, 8'd6, 8'd254, 8'd2};
    // 2,3: peaks two bins apart
    frames[2].len = 12; frames[2].samp[5] = 40; frames[2].samp[7] = 60;
    frames[2].ep = {24'd0, 8'd60}; frames[2].ei = {24'd0, 8'd7}; frames[2].ec = 1; frames[2].es = 4'b0000;
    frames[3].len = 12; frames[3].samp[5] = 60; frames[3].samp[7] = 40;
    frames[3].ep = {24'd0, 8'd60}; frames[3].ei = {24'd0, 8'd5}; frames[3].ec = 1; frames[3].es = 4'b0001;
    // 4,5: both are local maxima, three bins apart -> holdoff decides
    frames[4].len = 12; frames[4].samp[5] = 40; frames[4].samp[8] = 60;
    frames[4].ep = {24'd0, 8'd60}; frames[4].ei = {24'd0, 8'd8}; frames[4].ec = 1; frames[4].es = 4'b0001;
    frames[5].len = 12; frames[5].samp[5] = 60; frames[5].samp[8] = 40;
    frames[5].ep = {24'd0, 8'd60}; frames[5].ei = {24'd0, 8'd5}; frames[5].ec = 1; frames[5].es = 4'b0001;
    // 6: holdoff across the index wrap (254 vs 1)
    frames[6].len = 10; frames[6].base = 252; frames[6].samp[2] = 40; frames[6].samp[5] = 60;
    frames[6].ep = {24'd0, 8'd60}; frames[6].ei = {24'd0, 8'd1}; frames[6].ec = 1; frames[6].es = 4'b0001;
    // 7: six peaks overflow a four-entry list
    frames[7].len = 25;
    frames[7].samp[2] = 20; frames[7].samp[6] = 90; frames[7].samp[10] = 30;
    frames[7].samp[14] = 70; frames[7].samp[18] = 50; frames[7].samp[22] = 60;
    frames[7].ep = {8'd50, 8'd60, 8'd70, 8'd90}; frames[7].ei = {8'd18, 8'd22, 8'd14, 8'd6};
    frames[7].ec = 4; frames[7].es = 4'b1111;
    // 8: plus a later 50 equal to the smallest entry -> unchanged
    frames[8] = frames[7]; frames[8].len = 29; frames[8].samp[26] = 50;
    // 9,10: threshold boundary, 5-beat frame is exactly one window
    frames[9].len = 5; frames[9].samp[2] = 10;
    frames[10].len = 5; frames[10].samp[2] = 11;
    frames[10].ep = {24'd0, 8'd11}; frames[10].ei = {24'd0, 8'd2}; frames[10].ec = 1; frames[10].es = 4'b0001;
    // 11: short frame
    frames[11].len = 4; frames[11].samp[2] = 50;
    // 12: plateau reports its first sample
    frames[12].len = 8; frames[12].samp[3] = 50; frames[12].samp[4] = 50;
    frames[12].ep = {24'd0, 8'd50}; frames[12].ei = {24'd0, 8'd3}; frames[12].ec = 1; frames[12].es = 4'b0001;
    // 13,14: side flag, left 5 / right 9 and mirrored
    frames[13].len = 5; frames[13].samp[0] = 5; frames[13].samp[1] = 5; frames[13].samp[2] = 40;
    frames[13].samp[3] = 9; frames[13].samp[4] = 9;
    frames[13].ep = {24'd0, 8'd40}; frames[13].ei = {24'd0, 8'd2}; frames[13].ec = 1; frames[13].es = 4'b0001;
    frames[14] = frames[13];
    frames[14].samp[0] = 9; frames[14].samp[1] = 9; frames[14].samp[3] = 5; frames[14].samp[4] = 5;
    frames[14].es = 4'b0000;

    #2 aresetn = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset peak_o", 64'(peak_o), 64'd0);
    chk("reset index_o", 64'(index_o), 64'd0);
    chk("reset count_o", 64'(count_o), 64'd0);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    aresetn = 1'b1;
    idle(2);

    // All frames back to back with no idle cycle in between.
    for (int f = 0; f < NF; f++) run_frame(f, 1'b0);
    idle(4);
    chk("hold peak_o", 64'(peak_o), 64'(frames[14].ep));
    chk("hold count_o", 64'(count_o), 64'(frames[14].ec));

    // Idle gaps with last high but valid low must not end the frame.
    run_frame(0, 1'b1);
    idle(4);
    chk("hold2 peak_o", 64'(peak_o), 64'(frames[0].ep));
    chk("hold2 index_o", 64'(index_o), 64'(frames[0].ei));

    // Reset in the middle of a frame: outputs clear, no publish follows.
    for (int b = 0; b < 9; b++) begin
      tick();
      valid   = 1'b1;
      last    = 1'b0;
      input_i = frames[7].samp[b];
      index_i = 8'(b);
    end
    @(negedge clk);
    valid = 1'b0;
    aresetn = 1'b0;
    #1;
    chk("midrst peak_o", 64'(peak_o), 64'd0);
    chk("midrst index_o", 64'(index_o), 64'd0);
    chk("midrst count_o", 64'(count_o), 64'd0);
    chk("midrst out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    aresetn = 1'b1;
    idle(3);
    chk("postrst peak_o", 64'(peak_o), 64'd0);
    run_frame(7, 1'b0);
    run_frame(12, 1'b0);
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/peak_k_shell.md
PEAK_K_SHELL -- requirements
Module: peak_k_shell

Interface
REQ-001 SHALL have parameter NUM_PEAKS, 4, number of tracked peaks K (1..8).
REQ-002 SHALL have parameter VALUE_WIDTH, `VALUE_WIDTH, sample width.
REQ-003 SHALL have parameter INDEX_WIDTH, `INDEX_WIDTH, bin index width.
REQ-004 SHALL have parameter HALF_WIN, 2, local-max half window W; window = 2W+1 samples.
REQ-005 SHALL have parameter HOLDOFF, `PEAK_HOLDOFF, minimum index separation between peaks.
REQ-006 SHALL have port clk  in  1  sole clock; rising edge.
REQ-007 SHALL have port aresetn  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have port valid  in  1  input beat qualifier.
REQ-009 SHALL have port last  in  1  final beat of frame; qualified by valid.
REQ-010 SHALL have port input_i  in  VALUE_WIDTH  unsigned sample.
REQ-011 SHALL have port index_i  in  INDEX_WIDTH  bin index of input_i.
REQ-012 SHALL have port threshold_i  in  VALUE_WIDTH  minimum peak value; quasi-static.
REQ-013 SHALL have port peak_o  out  K*VALUE_WIDTH  published peaks, slot 0 largest.
REQ-014 SHALL have port index_o  out  K*INDEX_WIDTH  published peak indices.
REQ-015 SHALL have port count_o  out  $clog2(K+1)  number of valid published slots.
REQ-016 SHALL have port out_valid  out  1  one-cycle publish pulse.
REQ-017 SHALL have port last_out  out  1  equals out_valid.

Function
REQ-018 SHALL delay input in a 2W+1 shift register advanced only on valid; centre = tap W; centre index = index_i - W modulo 2^INDEX_WIDTH.
REQ-019 SHALL FSM: IDLE (post reset) -> FILL on first valid; FILL -> RUN once 2W+1 beats of current frame received; any state -> FILL on valid&&last.
REQ-020 SHALL flag a candidate only in RUN on a valid beat: centre > every older tap, centre >= every newer tap, centre > threshold_i.
REQ-021 SHALL, for a candidate within HOLDOFF (modular |dIndex| <= HOLDOFF) of a stored entry, replace that entry only if candidate strictly larger, else discard.
REQ-022 SHALL otherwise insert candidate in descending order if list not full or candidate > smallest entry; smallest drops off; equal values keep existing entry.
REQ-023 SHALL keep list sorted after every update; insertion/replacement completes in the same cycle as the valid beat.
REQ-024 SHALL on valid&&last load outputs from the post-update list (including that beat's candidate) and assert out_valid on the following cycle; list and window count clear in the same cycle.
REQ-025 SHALL hold peak_o/index_o/count_o stable between publishes; unused slots read 0.
REQ-026 SHALL treat a frame shorter than 2W+1 beats as publishing count_o = 0.
REQ-027 SHALL ignore last when valid is low; back-to-back frames with no idle cycle SHALL be supported.

Reset
REQ-028 SHALL on aresetn low clear list, window, count_o, peak_o, index_o, out_valid, last_out to 0 and enter IDLE asynchronously.
REQ-029 SHALL deassert reset synchronously to clk; reset mid-frame discards that frame with no publish.

Configuration
REQ-030 SHALL with PEAK_SIDE_EN defined add port side_o out K: per peak, 1 if tap 2W >= tap 0 at capture, else 0; travels with its entry, reset 0.
REQ-031 SHALL without PEAK_SIDE_EN omit side_o and its storage entirely.

Structure
REQ-032 SHALL take VALUE_WIDTH, INDEX_WIDTH, PEAK_HOLDOFF, NUM_BINS defaults from shared constants.vh; add NUM_PEAKS default there.
REQ-033 SHALL place sorted-list insert/replace logic in sub-module peak_topk_list.

Verification (K=4, W=2, HOLDOFF=3, threshold 10)
REQ-034 SHALL test: frame 0,0,50,0,0,0,80,0,0,0,30,0,0 idx 0..12, last on 12 -> out_valid next cycle, peak_o 80,50,30,0, index_o 6,2,10,0, count 3.
REQ-035 SHALL test holdoff: peaks 40@idx5 and 60@idx7 -> single entry 60@7; 60@5 then 40@7 -> 60@5 kept.
REQ-036 SHALL test overflow: six isolated peaks 20,90,30,70,50,60 -> 90,70,60,50; equal 50 later -> list unchanged.
REQ-037 SHALL test threshold: peak value 10 -> rejected, count 0; short frame of 4 beats -> count 0.
REQ-038 SHALL test back-to-back frames and aresetn pulsed mid-frame -> outputs 0, no out_valid, next frame correct.
REQ-039 SHALL test PEAK_SIDE_EN: neighbours 5 left, 9 right of peak -> side_o bit 1.
